// File: rtl/regfile_multiport.sv
// regfile_multiport
//   General-purpose register file for the MIPS datapath.
//   - NUM_RD registered read ports (1-cycle latency, write-first bypass)
//   - one write port with byte enables and optional zero-extend
//   - per-register busy scoreboard reported on each read port
//   - optional hardwired zero register (ZERO_REG=1)
// Ports
//   i_clk, i_rst        rising-edge clock, asynchronous active-high reset
//   i_rd_en/i_rd_addr   per-port read request and address (packed by port)
//   o_rd_data           per-port read data, holds while the port is idle
//   o_rd_valid          per-port: o_rd_data was updated by the last edge
//   o_rd_busy           per-port: addressed register busy after last edge
//   i_wr_*              write strobe, address, data, byte enables, zext
//   i_set_busy          mark register i_busy_addr as pending
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_valid,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [DATA_W/8-1:0]      i_wr_be,
  input  logic                     i_wr_zext,
  input  logic                     i_set_busy,
  input  logic [ADDR_W-1:0]        i_busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Expand each byte-enable bit into a full byte of mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [DEPTH-1:0]         w_busy_next;
  logic [DATA_W-1:0]        w_mask;
  logic [DATA_W-1:0]        w_new;
  logic                     w_wr_ok;
  logic                     w_set_ok;
  logic [NUM_RD*DATA_W-1:0] w_rd_data_next;
  logic [NUM_RD-1:0]        w_rd_busy_next;

  // Register 0 swallows writes and busy marks when it is hardwired to zero;
  // since it is never written it keeps its reset value of 0.
  assign w_wr_ok  = i_wr_en &&
                    !((ZERO_REG != 0) && (i_wr_addr == {ADDR_W{1'b0}}));
  assign w_set_ok = i_set_busy &&
                    !((ZERO_REG != 0) && (i_busy_addr == {ADDR_W{1'b0}}));
  assign w_mask   = be_to_mask(i_wr_be);

  // Merge write data into the old register contents (or zero-extend).
  always_comb begin
    w_new = {DATA_W{1'b0}};
    if (i_wr_zext) begin
      w_new = i_wr_data & w_mask;
    end else begin
      w_new = (r_mem[i_wr_addr] & ~w_mask) | (i_wr_data & w_mask);
    end
  end

  // Next busy vector: a write clears, then a set marks a new producer.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_ok) begin
      w_busy_next[i_wr_addr] = 1'b0;
    end else begin
      w_busy_next[i_wr_addr] = r_busy[i_wr_addr];
    end
    if (w_set_ok) begin
      w_busy_next[i_busy_addr] = 1'b1;
    end else begin
      w_busy_next[i_busy_addr] = w_busy_next[i_busy_addr];
    end
  end

  // Per-port read value with write-first bypass and post-update busy bit.
  always_comb begin
    w_rd_data_next = {(NUM_RD*DATA_W){1'b0}};
    w_rd_busy_next = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      if (w_wr_ok && (i_rd_addr[p*ADDR_W +: ADDR_W] == i_wr_addr)) begin
        w_rd_data_next[p*DATA_W +: DATA_W] = w_new;
      end else begin
        w_rd_data_next[p*DATA_W +: DATA_W] = r_mem[i_rd_addr[p*ADDR_W +: ADDR_W]];
      end
      w_rd_busy_next[p] = w_busy_next[i_rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  // Register array write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= w_new;
    end
  end

  // Busy scoreboard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Registered read outputs; an idle port holds its data and drops valid/busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data  <= {(NUM_RD*DATA_W){1'b0}};
      o_rd_valid <= {NUM_RD{1'b0}};
      o_rd_busy  <= {NUM_RD{1'b0}};
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (i_rd_en[p]) begin
          o_rd_data[p*DATA_W +: DATA_W] <= w_rd_data_next[p*DATA_W +: DATA_W];
          o_rd_valid[p]                 <= 1'b1;
          o_rd_busy[p]                  <= w_rd_busy_next[p];
        end else begin
          o_rd_valid[p] <= 1'b0;
          o_rd_busy[p]  <= 1'b0;
        end
      end
    end
  end

endmodule
